reward_source: RTL and testbench
================================

# reward_source

Environment model for the bandit: consumes the 8-bit action issued by the action-value agent and returns an 8-bit signed reward drawn from a per-arm mean table plus pseudorandom noise. It sits directly downstream of the agent's action port and directly upstream of the agent's reward port, closing the agent–environment loop in simulation and on hardware. A host write port reprograms arm means at runtime, and a pull counter exposes progress.

## Interface
- INIT, "", hex file for the 256×8 mean table; empty means all means are 0.
- SEED, 16'hace1, LFSR reset value; must be nonzero.
- TAPS, 16'hb400, Fibonacci LFSR tap mask (x^16+x^14+x^13+x^11+1).
- NOISE_SHIFT, 4, arithmetic right shift applied to noise; 0..7 valid, ≥8 disables noise.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- action_valid  in  1  action offered.
- action_data  in  8  arm index.
- action_ready  out  1  block accepts action.
- reward_valid  out  1  reward offered.
- reward_data  out  8  signed reward.
- reward_ready  in  1  consumer accepts reward.
- mean_we  in  1  host table write strobe.
- mean_addr  in  8  host write address.
- mean_data  in  8  signed mean to write.
- pulls  out  16  completed reward handshakes, saturating.

## Operation
- FSM states: IDLE, LOOKUP, SCORE, PRESENT.
  - IDLE → LOOKUP on action_valid & action_ready; the block latches action_data into the internal arm register.
  - LOOKUP → SCORE unconditionally; the block registers mean <= table[arm].
  - SCORE → PRESENT unconditionally; the block registers the reward.
  - PRESENT → IDLE on reward_ready.
- action_ready = (state==IDLE) & ~reset.
- reward_valid = (state==PRESENT).
- LFSR: 16-bit, free-running every cycle, reset to SEED. Update: lfsr <= {lfsr[14:0], ^(lfsr & TAPS)}.
- Noise: n = $signed(lfsr[7:0]) >>> NOISE_SHIFT, sampled in SCORE. n = 0 if NOISE_SHIFT ≥ 8.
- Reward arithmetic:
  - sum = sign-extend(mean, 9) + sign-extend(n, 9).
  - Saturate to [-128, 127]: sum > 127 gives 8'h7f; sum < -128 gives 8'h80.
- Table: 256×8 synchronous RAM with one write port (host) and one read port (LOOKUP).
  - Writes happen whenever mean_we=1, in any state.
  - A same-address write and read in the same cycle returns the old value (read-before-write).
- pulls: increments on reward_valid & reward_ready and holds at 16'hffff.
- Reset values:
  - state=IDLE, reward_data=0, reward_valid=0, pulls=0, lfsr=SEED.
  - action_ready=0 while reset is high and 1 the first cycle after it falls.
  - The table is not cleared by reset.

## Timing
- Action handshake at cycle T gives reward_valid=1 starting at cycle T+3.
- reward_data and reward_valid stay stable until the handshake.
- After a reward handshake at cycle R, action_ready=1 at R+1. Minimum period is 4 cycles per action.
- No combinational path from any input to action_ready or reward_valid. Only reset gates action_ready.
- Simultaneous action_valid and reset: the action is ignored.
- Reset in LOOKUP, SCORE or PRESENT: the pending action and reward are discarded with no handshake, and pulls returns to 0.
- Host write to arm[k] while an action for k is in flight:
  - Visible to that action only if the write lands before the LOOKUP cycle.
  - A write in the LOOKUP cycle is seen by the next pull.
- pulls at 16'hffff stays at 16'hffff on further handshakes.

## Test plan
- NOISE_SHIFT=8, write mean[5]=8'h40, action 5 at T → reward_valid at T+3 with reward_data=8'h40; pulls=1 after the handshake.
- NOISE_SHIFT=0, mean[9]=8'h7f, LFSR state giving lfsr[7:0]=8'h30 at SCORE → reward 8'h7f. Same with mean=8'h80 and lfsr[7:0]=8'hd0 → reward 8'h80.
- Backpressure: hold reward_ready low for 10 cycles → reward_data and reward_valid stay constant, action_ready=0 throughout, action_valid is ignored. Release → action_ready=1 next cycle.
- Assert reset in PRESENT → the next cycle has reward_valid=0 and pulls=0. After deassertion, action_ready=1 and a fresh action completes normally.
- Write collision, NOISE_SHIFT=8, mean[3]=8'h10:
  - Write mean[3]=8'h20 in the LOOKUP cycle of action 3 → reward 8'h10.
  - Next pull of arm 3 → reward 8'h20.
- Issue 65537 back-to-back pulls with reward_ready tied high → pulls reads 16'hffff and stays there. Each action period is exactly 4 cycles.

Source files
------------

// File: rtl/reward_source_if.sv
// reward_source_if: action/reward handshakes plus the host mean-table write port
interface reward_source_if;
    logic       action_valid;
    logic [7:0] action_data;
    logic       action_ready;
    logic       reward_valid;
    logic [7:0] reward_data;
    logic       reward_ready;
    logic       mean_we;
    logic [7:0] mean_addr;
    logic [7:0] mean_data;
    modport master (
        output action_valid, action_data, reward_ready, mean_we, mean_addr, mean_data,
        input  action_ready, reward_valid, reward_data
    );
    modport slave (
        input  action_valid, action_data, reward_ready, mean_we, mean_addr, mean_data,
        output action_ready, reward_valid, reward_data
    );
endinterface

// File: rtl/reward_source.sv
// reward_source: bandit environment returning a per-arm mean plus LFSR noise for each pulled arm
module reward_source #(
    parameter string       INIT        = "",
    parameter logic [15:0] SEED        = 16'hace1,
    parameter logic [15:0] TAPS        = 16'hb400,
    parameter int          NOISE_SHIFT = 4
) (
    input  logic           clock,
    input  logic           reset,
    reward_source_if.slave bus,
    output logic [15:0]    pulls
);
    typedef enum logic [1:0] {IDLE, LOOKUP, SCORE, PRESENT} state_t;
    localparam int SHIFT = NOISE_SHIFT >= 8 ? 0 : NOISE_SHIFT;

    logic [255:0][7:0] table_mem = '0;
    state_t            state, next_state;
    logic [7:0]        arm, mean;
    logic [15:0]       lfsr;
    logic signed [7:0] noise;
    logic [8:0]        sum;

    // state register
    always_ff @(posedge clock) state <= reset ? IDLE : next_state;

    // next state: step through lookup and score, hold in present until the reward is taken
    always_comb next_state = state == IDLE   ? (bus.action_valid ? LOOKUP : IDLE) :
                             state == LOOKUP ? SCORE :
                             state == SCORE  ? PRESENT :
                             bus.reward_ready ? IDLE : PRESENT;

    // handshake outputs decoded from state; reset is the only input reaching action_ready
    always_comb begin
        bus.action_ready = state == IDLE && !reset;
        bus.reward_valid = state == PRESENT;
    end

    // shifted noise and the 9-bit sum whose top two bits disagree exactly on overflow
    always_comb begin
        noise = NOISE_SHIFT >= 8 ? 8'sd0 : $signed(lfsr[7:0]) >>> SHIFT;
        sum   = {mean[7], mean} + {noise[7], noise};
    end

    // free-running Fibonacci LFSR
    always_ff @(posedge clock) lfsr <= reset ? SEED : {lfsr[14:0], ^(lfsr & TAPS)};

    // host writes land in any state; a same-address lookup sees the old word
    always_ff @(posedge clock) begin
        if (bus.mean_we) table_mem[bus.mean_addr] <= bus.mean_data;
        if (state == LOOKUP) mean <= table_mem[arm];
    end

    // arm latch, saturated reward register and saturating pull counter
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.reward_data <= '0;
            pulls           <= '0;
        end else begin
            if (state == IDLE && bus.action_valid) arm <= bus.action_data;
            if (state == SCORE) bus.reward_data <= sum[8] != sum[7] ? {sum[8], {7{~sum[8]}}} : sum[7:0];
            if (bus.reward_valid && bus.reward_ready && pulls != 16'hffff) pulls <= pulls + 1'b1;
        end
    end
endmodule

// File: tb/tb_reward_source.sv
// tb_reward_source: directed and randomized checks of reward_source against a behavioural model
module tb_reward_source;
    localparam logic [15:0] SEED = 16'hace1;
    localparam logic [15:0] TAPS = 16'hb400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       action_valid = 1'b0, reward_ready = 1'b0, mean_we = 1'b0;
    logic [7:0] action_data = '0, mean_addr = '0, mean_data = '0;
    logic       ar [3];
    logic       rv [3];
    logic [7:0] rd [3];
    logic [15:0] pl [3];
    logic [7:0] got [3];
    logic       preset_on = 1'b0;
    int         n_checks = 0, n_fail = 0;

    always #5 clock = ~clock;

    // three instances share stimulus: noise disabled, unshifted, and default shift
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            reward_source_if bus ();
            assign bus.action_valid = action_valid;
            assign bus.action_data  = action_data;
            assign bus.reward_ready = reward_ready;
            assign bus.mean_we      = mean_we;
            assign bus.mean_addr    = mean_addr;
            assign bus.mean_data    = mean_data;
            assign ar[g] = bus.action_ready;
            assign rv[g] = bus.reward_valid;
            assign rd[g] = bus.reward_data;
            reward_source #(.NOISE_SHIFT(g == 0 ? 8 : g == 1 ? 0 : 4)) dut (
                .clock(clock), .reset(reset), .bus(bus), .pulls(pl[g])
            );
        end
    endgenerate

    function automatic int shift_of(int i);
        return i == 0 ? 8 : i == 1 ? 0 : 4;
    endfunction

    function automatic logic [15:0] step(logic [15:0] l);
        return {l[14:0], ^(l & TAPS)};
    endfunction

    // reward as plain integer arithmetic: mean + shifted noise, clamped to the signed byte range
    function automatic logic [7:0] predict(logic [7:0] mean, logic [7:0] l8, int sh);
        int n, s;
        n = sh >= 8 ? 0 : (int'($signed(l8)) >>> sh);
        s = int'($signed(mean)) + n;
        s = s > 127 ? 127 : s < -128 ? -128 : s;
        return s[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // behavioural model: timestamps of the accepted action decide when lookup and scoring happen
    int          cyc = 0, t_hs = 0;
    bit          busy = 1'b0, m_valid = 1'b0;
    logic [7:0]  m_arm = '0, m_mean = '0;
    logic [7:0]  m_data [3] = '{default: '0};
    logic [15:0] m_pulls = '0, m_lfsr = SEED;
    logic [7:0]  m_tab [256] = '{default: '0};

    initial forever begin
        @(posedge clock);
        if (reset) begin
            busy = 1'b0;
            m_valid = 1'b0;
            m_pulls = '0;
            m_lfsr = SEED;
            for (int i = 0; i < 3; i++) m_data[i] = '0;
        end else begin
            if (m_valid && reward_ready) begin
                m_valid = 1'b0;
                busy = 1'b0;
                if (m_pulls != 16'hffff) m_pulls++;
            end else if (!busy && action_valid) begin
                busy = 1'b1;
                t_hs = cyc;
                m_arm = action_data;
            end else if (busy && cyc == t_hs + 1) begin
                m_mean = m_tab[m_arm];
            end else if (busy && cyc == t_hs + 2) begin
                m_valid = 1'b1;
                for (int i = 0; i < 3; i++) m_data[i] = predict(m_mean, m_lfsr[7:0], shift_of(i));
            end
            if (preset_on) m_pulls = 16'hfffd;
            m_lfsr = step(m_lfsr);
        end
        if (mean_we) m_tab[mean_addr] = mean_data;
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("action_ready[%0d]", i), 32'(ar[i]), 32'(!busy && !reset));
            check($sformatf("reward_valid[%0d]", i), 32'(rv[i]), 32'(m_valid));
            check($sformatf("pulls[%0d]", i), 32'(pl[i]), 32'(m_pulls));
            if (m_valid) check($sformatf("reward_data[%0d]", i), 32'(rd[i]), 32'(m_data[i]));
        end
    end

    task automatic write(input logic [7:0] addr, input logic [7:0] data);
        mean_we = 1'b1;
        mean_addr = addr;
        mean_data = data;
        tick();
        mean_we = 1'b0;
    endtask

    // one complete pull; optional host write in the lookup cycle and a backpressure hold
    task automatic pull(input logic [7:0] arm, input int hold, input bit wr, input logic [7:0] wdata);
        int k;
        action_valid = 1'b1;
        action_data = arm;
        reward_ready = 1'b0;
        k = 0;
        while (!ar[0] && k < 20) begin
            tick();
            k++;
        end
        check("action_ready_wait", 32'(ar[0]), 32'd1);
        tick();
        action_valid = 1'b0;
        if (wr) begin
            mean_we = 1'b1;
            mean_addr = arm;
            mean_data = wdata;
        end
        k = 1;
        while (!rv[0] && k < 10) begin
            tick();
            mean_we = 1'b0;
            k++;
        end
        mean_we = 1'b0;
        check("reward_latency", 32'(k), 32'd3);
        for (int i = 0; i < 3; i++) got[i] = rd[i];
        for (int c = 0; c < hold; c++) begin
            action_valid = 1'b1;
            tick();
            for (int i = 0; i < 3; i++) begin
                check($sformatf("hold_valid[%0d]", i), 32'(rv[i]), 32'd1);
                check($sformatf("hold_data[%0d]", i), 32'(rd[i]), 32'(got[i]));
                check($sformatf("hold_ready[%0d]", i), 32'(ar[i]), 32'd0);
            end
        end
        action_valid = 1'b0;
        reward_ready = 1'b1;
        tick();
        reward_ready = 1'b0;
        for (int i = 0; i < 3; i++) check($sformatf("ready_after_reward[%0d]", i), 32'(ar[i]), 32'd1);
    endtask

    // idle until the unshifted instance will score with the requested low LFSR byte
    task automatic wait_lfsr(input logic [7:0] target);
        int k;
        logic [15:0] l;
        k = 0;
        l = step(step(m_lfsr));
        while (l[7:0] != target && k < 8000) begin
            tick();
            k++;
            l = step(step(m_lfsr));
        end
        check("lfsr_search", 32'(l[7:0]), 32'(target));
    endtask

    initial begin
        int k, last;
        check("model_lfsr_step", 32'(step(SEED)), 32'h59c3);
        check("model_sat_hi", 32'(predict(8'h7f, 8'h30, 0)), 32'h7f);
        check("model_sat_lo", 32'(predict(8'h80, 8'hd0, 0)), 32'h80);
        check("model_shift4", 32'(predict(8'h10, 8'hf0, 4)), 32'h0f);
        check("model_no_noise", 32'(predict(8'h40, 8'hff, 8)), 32'h40);

        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready[%0d]", i), 32'(ar[i]), 32'd0);
            check($sformatf("rst_valid[%0d]", i), 32'(rv[i]), 32'd0);
            check($sformatf("rst_data[%0d]", i), 32'(rd[i]), 32'd0);
            check($sformatf("rst_pulls[%0d]", i), 32'(pl[i]), 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("ready_after_rst[%0d]", i), 32'(ar[i]), 32'd1);
        tick();

        write(8'd5, 8'h40);
        write(8'd3, 8'h10);
        pull(8'd5, 0, 1'b0, 8'h00);
        check("mean5_reward", 32'(got[0]), 32'h40);
        for (int i = 0; i < 3; i++) check($sformatf("first_pull[%0d]", i), 32'(pl[i]), 32'd1);

        pull(8'd5, 10, 1'b0, 8'h00);
        check("backpressure_reward", 32'(got[0]), 32'h40);

        pull(8'd3, 0, 1'b1, 8'h20);
        check("collision_old", 32'(got[0]), 32'h10);
        pull(8'd3, 0, 1'b0, 8'h00);
        check("collision_new", 32'(got[0]), 32'h20);

        write(8'd9, 8'h7f);
        wait_lfsr(8'h30);
        pull(8'd9, 0, 1'b0, 8'h00);
        check("sat_high", 32'(got[1]), 32'h7f);
        write(8'd9, 8'h80);
        wait_lfsr(8'hd0);
        pull(8'd9, 0, 1'b0, 8'h00);
        check("sat_low", 32'(got[1]), 32'h80);

        action_valid = 1'b1;
        action_data = 8'd5;
        tick();
        action_valid = 1'b0;
        k = 0;
        while (!rv[0] && k < 10) begin
            tick();
            k++;
        end
        check("present_reached", 32'(rv[0]), 32'd1);
        reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("present_rst_valid[%0d]", i), 32'(rv[i]), 32'd0);
            check($sformatf("present_rst_pulls[%0d]", i), 32'(pl[i]), 32'd0);
            check($sformatf("present_rst_data[%0d]", i), 32'(rd[i]), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("ready_after_present_rst", 32'(ar[0]), 32'd1);
        tick();
        pull(8'd5, 0, 1'b0, 8'h00);
        check("fresh_pull", 32'(got[0]), 32'h40);
        check("fresh_pulls", 32'(pl[0]), 32'd1);

        for (int c = 0; c < 3000; c++) begin
            reset = $urandom_range(0, 299) == 0;
            action_valid = 1'($urandom_range(0, 1));
            action_data = 8'($urandom_range(0, 15));
            reward_ready = $urandom_range(0, 3) != 0;
            mean_we = $urandom_range(0, 3) == 0;
            mean_addr = 8'($urandom_range(0, 15));
            mean_data = 8'($urandom);
            tick();
        end

        reset = 1'b1;
        action_valid = 1'b0;
        reward_ready = 1'b0;
        mean_we = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        force g_dut[0].dut.pulls = 16'hfffd;
        force g_dut[1].dut.pulls = 16'hfffd;
        force g_dut[2].dut.pulls = 16'hfffd;
        preset_on = 1'b1;
        tick();
        release g_dut[0].dut.pulls;
        release g_dut[1].dut.pulls;
        release g_dut[2].dut.pulls;
        preset_on = 1'b0;
        for (int i = 0; i < 3; i++) check($sformatf("preset_pulls[%0d]", i), 32'(pl[i]), 32'hfffd);

        action_valid = 1'b1;
        action_data = 8'd7;
        reward_ready = 1'b1;
        last = -1;
        for (int c = 0; c < 48; c++) begin
            if (ar[0]) begin
                if (last >= 0) check("action_period", 32'(c - last), 32'd4);
                last = c;
            end
            tick();
        end
        action_valid = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 3; i++) check($sformatf("saturated_pulls[%0d]", i), 32'(pl[i]), 32'hffff);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
